// File: rtl/slow_access_timer_if.sv
// slow_access_timer_if
//   Bus-cycle and clock-switcher handshake seen by slow_access_timer.
//   BACT            CPU bus cycle active
//   IACKCS..SndCS   device selects, valid while BACT
//   SlowAck         clock switcher reports slow clock running
//   SlowReq         slow-mode request to the clock switcher
//   Stall           wait-state request back to the bus cycle
//   master: bus/switcher side, slave: the timer.
interface slow_access_timer_if;
    logic BACT;
    logic IACKCS;
    logic VIACS;
    logic IWMCS;
    logic SCCCS;
    logic SCSICS;
    logic SndCS;
    logic SlowAck;
    logic SlowReq;
    logic Stall;

    modport master (
        output BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS, SlowAck,
        input  SlowReq, Stall
    );

    modport slave (
        input  BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS, SlowAck,
        output SlowReq, Stall
    );
endinterface

// File: rtl/slow_access_timer.sv
// slow_access_timer
//   Requests slow clock mode for bus cycles that target devices whose slow
//   enable is set, stalls those cycles until the clock switcher acknowledges,
//   and keeps slow mode for SlowTimeout timer ticks after the cycle ends
//   (4'hF holds slow mode indefinitely).
// Ports
//   CLK            system clock, rising edge
//   nPOR           asynchronous active-low reset
//   bus            slave side of slow_access_timer_if (BACT, selects,
//                  SlowAck in; SlowReq, Stall out, both registered)
//   SlowIACK..SlowSnd  per-device slow enables
//   SlowClockGate  force SlowReq high regardless of the FSM
//   SlowTimeout    hold time in TimerTick units, sampled at load
//   TimerTick      one-cycle timebase strobe
//   SlowCount      remaining hold ticks (debug)
module slow_access_timer (
    input  logic              CLK,
    input  logic              nPOR,
    slow_access_timer_if.slave bus,
    input  logic              SlowIACK,
    input  logic              SlowVIA,
    input  logic              SlowIWM,
    input  logic              SlowSCC,
    input  logic              SlowSCSI,
    input  logic              SlowSnd,
    input  logic              SlowClockGate,
    input  logic [3:0]        SlowTimeout,
    input  logic              TimerTick,
    output logic [3:0]        SlowCount
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        COUNT
    } state_t;

    state_t     state;
    state_t     stateNext;
    logic [3:0] countNext;
    logic       bactR;
    logic       start;
    logic       hit;
    logic       reqNext;
    logic       stallNext;
    logic [5:0] selects;
    logic [5:0] enables;

    assign selects = {bus.IACKCS, bus.VIACS, bus.IWMCS, bus.SCCCS, bus.SCSICS, bus.SndCS};
    assign enables = {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd};

    // Only the first BACT cycle of a bus cycle can hit.
    assign start = bus.BACT & ~bactR;
    assign hit   = start & (|(selects & enables));

    // State register; SlowReq/Stall are registered from the current state,
    // so they follow a transition by one edge.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state       <= IDLE;
            SlowCount   <= '0;
            bactR       <= 1'b0;
            bus.SlowReq <= 1'b0;
            bus.Stall   <= 1'b0;
        end else begin
            state       <= stateNext;
            SlowCount   <= countNext;
            bactR       <= bus.BACT;
            bus.SlowReq <= reqNext;
            bus.Stall   <= stallNext;
        end
    end

    // Next state. In COUNT the order of tests sets priority:
    // hit > ack loss > never-expire > expiry > tick.
    always_comb begin
        stateNext = state;
        countNext = SlowCount;
        case (state)
            IDLE: begin
                if (hit) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (bus.SlowAck) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (!bus.BACT) begin
                    // Load wins over any tick on this edge.
                    stateNext = COUNT;
                    countNext = SlowTimeout;
                end else if (!bus.SlowAck) begin
                    stateNext = REQ;
                end
            end
            COUNT: begin
                if (hit) begin
                    stateNext = HOLD;
                end else if (bus.BACT && !bus.SlowAck) begin
                    stateNext = REQ;
                end else if (SlowTimeout != 4'hF) begin
                    if (SlowCount == '0) begin
                        stateNext = IDLE;
                    end else if (TimerTick) begin
                        countNext = SlowCount - 4'd1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output decode (registered in the state register process).
    always_comb begin
        reqNext   = (state != IDLE) | SlowClockGate;
        stallNext = (state == REQ);
    end

endmodule
